// File: rtl/branch_resolve_stage_pkg.sv
// Shared types and constants for the EX-stage branch resolution path.
// Holds funct3 branch encodings, the default datapath width and the adder flag bundle.
package branch_resolve_stage_pkg;

    localparam int XLEN_DEF = 64;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Flags produced by the adder when it computes rs1 + ~rs2 + 1.
    typedef struct packed {
        logic c_out;
        logic v;
        logic n;
        logic z;
    } adder_flags_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational RISC-V branch condition from funct3 and adder flags.
// Ports: funct3_i (branch type), flags_i (adder flags), taken_o (condition true).
module branch_cond_eval
    import branch_resolve_stage_pkg::*;
(
    input  logic [2:0]   funct3_i,
    input  adder_flags_t flags_i,
    output logic         taken_o
);

    always_comb begin
        taken_o = 1'b0;
        unique case (funct3_i)
            BR_BEQ:  taken_o = flags_i.z;
            BR_BNE:  taken_o = !flags_i.z;
            BR_BLT:  taken_o = flags_i.n ^ flags_i.v;
            BR_BGE:  taken_o = !(flags_i.n ^ flags_i.v);
            // No borrow out of rs1 - rs2 means rs1 >= rs2 unsigned.
            BR_BLTU: taken_o = !flags_i.c_out;
            BR_BGEU: taken_o = flags_i.c_out;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_stage.sv
// EX-stage branch resolution: evaluates the branch condition, registers the result
// into EX/MEM under valid/ready, and raises a one-cycle redirect on mispredict.
// Ports: in_* upstream EX bundle + handshake, out_* registered EX/MEM bundle,
// redirect_valid/redirect_pc to fetch, epoch fed back to fetch, mispredict_cnt stats.
module branch_resolve_stage
    import branch_resolve_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_sum,
    input  logic             in_c_out,
    input  logic             in_v_flag,
    input  logic             in_n_flag,
    input  logic             in_z_flag,
    input  logic             in_is_branch,
    input  logic             in_is_jump,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_target,
    input  logic             in_pred_taken,
    input  logic             in_epoch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_result,
    output logic             out_taken,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             epoch,
    output logic [CNT_W-1:0] mispredict_cnt
);

    adder_flags_t flags;
    logic         cond_taken;
    logic         taken;
    logic         accept;
    logic         load;
    logic         mispredict;
    logic [XLEN-1:0] pc_plus4;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_pc_q, out_pc_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic             out_taken_q, out_taken_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             epoch_q, epoch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign flags = '{c_out: in_c_out, v: in_v_flag, n: in_n_flag, z: in_z_flag};

    branch_cond_eval u_cond (
        .funct3_i (in_funct3),
        .flags_i  (flags),
        .taken_o  (cond_taken)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // Stale-epoch instructions are consumed but never reach the output.
    assign load     = accept && (in_epoch == epoch_q);
    assign pc_plus4 = in_pc + XLEN'(4);

    always_comb begin
        taken = 1'b0;
        if (in_is_jump) begin
            taken = 1'b1;
        end else if (in_is_branch) begin
            taken = cond_taken;
        end
    end

    assign mispredict = load && (in_is_branch || in_is_jump)
                        && (taken != in_pred_taken);

    always_comb begin
        out_valid_d      = out_valid_q && !out_ready;
        out_pc_d         = out_pc_q;
        out_result_d     = out_result_q;
        out_taken_d      = out_taken_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        epoch_d          = epoch_q;
        cnt_d            = cnt_q;
        if (load) begin
            out_valid_d  = 1'b1;
            out_pc_d     = in_pc;
            out_result_d = in_is_jump ? pc_plus4 : in_sum;
            out_taken_d  = taken;
        end
        if (mispredict) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = taken ? in_target : pc_plus4;
            epoch_d          = !epoch_q;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            out_pc_q         <= '0;
            out_result_q     <= '0;
            out_taken_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            epoch_q          <= 1'b0;
            cnt_q            <= '0;
        end else begin
            out_valid_q      <= out_valid_d;
            out_pc_q         <= out_pc_d;
            out_result_q     <= out_result_d;
            out_taken_q      <= out_taken_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            epoch_q          <= epoch_d;
            cnt_q            <= cnt_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = out_pc_q;
    assign out_result     = out_result_q;
    assign out_taken      = out_taken_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign epoch          = epoch_q;
    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Self-checking bench for branch_resolve_stage (XLEN=64, CNT_W=4).
// Directed scenarios plus randomized traffic against a comparison-based model.
module tb_branch_resolve_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_sum;
    logic             in_c_out;
    logic             in_v_flag;
    logic             in_n_flag;
    logic             in_z_flag;
    logic             in_is_branch;
    logic             in_is_jump;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_target;
    logic             in_pred_taken;
    logic             in_epoch;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_result;
    logic             out_taken;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             epoch;
    logic [CNT_W-1:0] mispredict_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state and expected outputs.
    logic             m_epoch;
    logic [CNT_W-1:0] m_cnt;
    logic             e_ov, e_taken, e_rv;
    logic [XLEN-1:0]  e_pc, e_res, e_rpc;

    always #5 clk = ~clk;

    branch_resolve_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_sum         (in_sum),
        .in_c_out       (in_c_out),
        .in_v_flag      (in_v_flag),
        .in_n_flag      (in_n_flag),
        .in_z_flag      (in_z_flag),
        .in_is_branch   (in_is_branch),
        .in_is_jump     (in_is_jump),
        .in_funct3      (in_funct3),
        .in_target      (in_target),
        .in_pred_taken  (in_pred_taken),
        .in_epoch       (in_epoch),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_result     (out_result),
        .out_taken      (out_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .epoch          (epoch),
        .mispredict_cnt (mispredict_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Adder front: rs1 + ~rs2 + 1 with its four flags.
    task automatic set_flags(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] d;
        d         = {1'b0, a} + {1'b0, ~b} + 65'd1;
        in_sum    = d[63:0];
        in_c_out  = d[64];
        in_n_flag = d[63];
        in_z_flag = (d[63:0] == 64'd0);
        in_v_flag = (a[63] != b[63]) && (d[63] != a[63]);
    endtask

    function automatic bit ref_taken(input logic [2:0] f3,
                                     input logic [63:0] a,
                                     input logic [63:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input bit br, input bit j, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b,
                         input bit pred, input logic [63:0] pc,
                         input logic [63:0] tgt, input bit ep);
        in_valid      = 1'b1;
        in_is_branch  = br;
        in_is_jump    = j;
        in_funct3     = f3;
        set_flags(a, b);
        in_pred_taken = pred;
        in_pc         = pc;
        in_target     = tgt;
        in_epoch      = ep;
    endtask

    // Model of one accepted transaction, assuming downstream is ready.
    task automatic model_step(input bit br, input bit j, input logic [2:0] f3,
                              input logic [63:0] a, input logic [63:0] b,
                              input bit pred, input logic [63:0] pc,
                              input logic [63:0] tgt, input bit ep);
        bit t;
        bit mis;
        if (ep != m_epoch) begin
            e_ov = 1'b0;
            e_rv = 1'b0;
        end else begin
            t       = j ? 1'b1 : (br ? ref_taken(f3, a, b) : 1'b0);
            e_ov    = 1'b1;
            e_taken = t;
            e_pc    = pc;
            e_res   = j ? pc + 64'd4 : a - b;
            mis     = (br || j) && (t != pred);
            e_rv    = mis;
            if (mis) begin
                e_rpc   = t ? tgt : pc + 64'd4;
                m_epoch = !m_epoch;
                if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
            end
        end
    endtask

    task automatic issue(input bit br, input bit j, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b,
                         input bit pred, input logic [63:0] pc,
                         input logic [63:0] tgt, input bit ep);
        int w;
        drive(br, j, f3, a, b, pred, pc, tgt, ep);
        #1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got in_ready=%b need 1", in_ready);
        end
        model_step(br, j, f3, a, b, pred, pc, tgt, ep);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 9;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b need 0", out_valid); end
        if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_redirect_valid got=%b need 0", redirect_valid); end
        if (epoch !== 1'b0) begin errors++; $display("FAIL rst_epoch got=%b need 0", epoch); end
        if (mispredict_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got=%h need 0", mispredict_cnt); end
        if (out_taken !== 1'b0) begin errors++; $display("FAIL rst_out_taken got=%b need 0", out_taken); end
        if (out_pc !== 64'd0) begin errors++; $display("FAIL rst_out_pc got=%h need 0", out_pc); end
        if (out_result !== 64'd0) begin errors++; $display("FAIL rst_out_result got=%h need 0", out_result); end
        if (redirect_pc !== 64'd0) begin errors++; $display("FAIL rst_redirect_pc got=%h need 0", redirect_pc); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b need 1", in_ready); end
        #3 rst_n = 1'b1;
        m_epoch = 1'b0;
        m_cnt   = '0;
        e_ov    = 1'b0;
        e_rv    = 1'b0;
        tick();
    endtask

    task automatic test_beq_mispredict();
        issue(1, 0, 3'b000, 64'd5, 64'd5, 0, 64'h100, 64'h1000, m_epoch);
        checks += 6;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL beq_valid got=%b need 1", out_valid); end
        if (out_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got=%b need 1", out_taken); end
        if (redirect_valid !== 1'b1) begin errors++; $display("FAIL beq_redirect got=%b need 1", redirect_valid); end
        if (redirect_pc !== 64'h1000) begin errors++; $display("FAIL beq_redirect_pc got=%h need 1000", redirect_pc); end
        if (epoch !== 1'b1) begin errors++; $display("FAIL beq_epoch got=%b need 1", epoch); end
        if (mispredict_cnt !== 4'd1) begin errors++; $display("FAIL beq_cnt got=%h need 1", mispredict_cnt); end
        in_valid = 1'b0;
        tick();
        checks += 2;
        if (redirect_valid !== 1'b0) begin errors++; $display("FAIL beq_pulse_once got=%b need 0", redirect_valid); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL beq_drain got=%b need 0", out_valid); end
    endtask

    task automatic test_blt_bltu();
        logic [63:0] m1;
        m1 = '1;
        issue(1, 0, 3'b100, m1, 64'd1, 1, 64'h200, 64'h2000, m_epoch);
        checks += 3;
        if (out_taken !== 1'b1) begin errors++; $display("FAIL blt_taken got=%b need 1", out_taken); end
        if (redirect_valid !== 1'b0) begin errors++; $display("FAIL blt_no_redirect got=%b need 0", redirect_valid); end
        if (epoch !== 1'b1) begin errors++; $display("FAIL blt_epoch got=%b need 1", epoch); end
        issue(1, 0, 3'b110, m1, 64'd1, 1, 64'h204, 64'h2000, m_epoch);
        checks += 4;
        if (out_taken !== 1'b0) begin errors++; $display("FAIL bltu_taken got=%b need 0", out_taken); end
        if (redirect_valid !== 1'b1) begin errors++; $display("FAIL bltu_redirect got=%b need 1", redirect_valid); end
        if (redirect_pc !== 64'h208) begin errors++; $display("FAIL bltu_redirect_pc got=%h need 208", redirect_pc); end
        if (epoch !== m_epoch) begin errors++; $display("FAIL bltu_epoch got=%b need %b", epoch, m_epoch); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_squash();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 3'b000, 64'd7, 64'd7, 0, 64'h300 + 64'(k * 4), 64'h3000, !m_epoch);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL squash_ready k=%0d got=%b need 1", k, in_ready); end
            model_step(1, 0, 3'b000, 64'd7, 64'd7, 0, 64'h300, 64'h3000, !m_epoch);
            tick();
            checks += 4;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL squash_valid k=%0d got=%b need 0", k, out_valid); end
            if (redirect_valid !== 1'b0) begin errors++; $display("FAIL squash_redirect k=%0d got=%b need 0", k, redirect_valid); end
            if (epoch !== m_epoch) begin errors++; $display("FAIL squash_epoch k=%0d got=%b need %b", k, epoch, m_epoch); end
            if (mispredict_cnt !== m_cnt) begin errors++; $display("FAIL squash_cnt k=%0d got=%h need %h", k, mispredict_cnt, m_cnt); end
        end
        issue(0, 0, 3'b000, 64'd50, 64'd8, 0, 64'h310, 64'h0, m_epoch);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL squash_resume got=%b need 1", out_valid); end
        if (out_result !== 64'd42) begin errors++; $display("FAIL squash_result got=%h need 2a", out_result); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back_stall();
        issue(0, 0, 3'b000, 64'd100, 64'd1, 0, 64'h400, 64'h0, m_epoch);
        out_ready = 1'b0;
        drive(0, 1, 3'b000, 64'd9, 64'd3, 1, 64'h404, 64'h4444, m_epoch);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b need 0", in_ready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks += 4;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid k=%0d got=%b need 1", k, out_valid); end
            if (out_pc !== e_pc) begin errors++; $display("FAIL stall_pc k=%0d got=%h need %h", k, out_pc, e_pc); end
            if (out_result !== e_res) begin errors++; $display("FAIL stall_result k=%0d got=%h need %h", k, out_result, e_res); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_hold k=%0d got=%b need 0", k, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL pop_ready got=%b need 1", in_ready); end
        model_step(0, 1, 3'b000, 64'd9, 64'd3, 1, 64'h404, 64'h4444, m_epoch);
        tick();
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL popload_valid got=%b need 1", out_valid); end
        if (out_pc !== 64'h404) begin errors++; $display("FAIL popload_pc got=%h need 404", out_pc); end
        if (out_result !== 64'h408) begin errors++; $display("FAIL popload_result got=%h need 408", out_result); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [63:0] a, b, pc, tgt;
        int kind;
        bit br, j, ep;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 99) < 15) begin
                in_valid = 1'b0;
                e_ov = 1'b0;
                e_rv = 1'b0;
                tick();
            end else begin
                kind = $urandom_range(0, 3);
                br   = (kind < 2);
                j    = (kind == 2);
                a    = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 8)) - 64'd4;
                b    = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
                pc   = {$urandom, $urandom[31:2], 2'b00};
                tgt  = {$urandom, $urandom[31:2], 2'b00};
                ep   = ($urandom_range(0, 7) == 0) ? !m_epoch : m_epoch;
                issue(br, j, 3'($urandom_range(0, 7)), a, b, 1'($urandom), pc, tgt, ep);
            end
            checks += 4;
            if (out_valid !== e_ov) begin errors++; $display("FAIL rand_valid it=%0d got=%b need %b", it, out_valid, e_ov); end
            if (redirect_valid !== e_rv) begin errors++; $display("FAIL rand_redirect it=%0d got=%b need %b", it, redirect_valid, e_rv); end
            if (epoch !== m_epoch) begin errors++; $display("FAIL rand_epoch it=%0d got=%b need %b", it, epoch, m_epoch); end
            if (mispredict_cnt !== m_cnt) begin errors++; $display("FAIL rand_cnt it=%0d got=%h need %h", it, mispredict_cnt, m_cnt); end
            if (e_ov) begin
                checks += 3;
                if (out_taken !== e_taken) begin errors++; $display("FAIL rand_taken it=%0d got=%b need %b", it, out_taken, e_taken); end
                if (out_pc !== e_pc) begin errors++; $display("FAIL rand_pc it=%0d got=%h need %h", it, out_pc, e_pc); end
                if (out_result !== e_res) begin errors++; $display("FAIL rand_result it=%0d got=%h need %h", it, out_result, e_res); end
            end
            if (e_rv) begin
                checks++;
                if (redirect_pc !== e_rpc) begin errors++; $display("FAIL rand_redirect_pc it=%0d got=%h need %h", it, redirect_pc, e_rpc); end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_wrap_saturate();
        issue(1, 0, 3'b000, 64'd1, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5000, m_epoch);
        checks += 2;
        if (redirect_valid !== 1'b1) begin errors++; $display("FAIL wrap_redirect got=%b need 1", redirect_valid); end
        if (redirect_pc !== 64'd0) begin errors++; $display("FAIL wrap_redirect_pc got=%h need 0", redirect_pc); end
        for (int k = 0; k < 20; k++) begin
            issue(0, 1, 3'b000, 64'd0, 64'd0, 0, 64'h600 + 64'(k * 4), 64'h6000, m_epoch);
            checks++;
            if (mispredict_cnt !== m_cnt) begin errors++; $display("FAIL sat_step k=%0d got=%h need %h", k, mispredict_cnt, m_cnt); end
        end
        checks++;
        if (mispredict_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got=%h need f", mispredict_cnt); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        if (m_epoch != 1'b1) begin
            issue(0, 1, 3'b000, 64'd0, 64'd0, 0, 64'h700, 64'h7000, m_epoch);
        end
        issue(0, 0, 3'b000, 64'd11, 64'd1, 0, 64'h704, 64'h0, m_epoch);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got=%b need 1", out_valid); end
        if (epoch !== 1'b1) begin errors++; $display("FAIL arst_pre_epoch got=%b need 1", epoch); end
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b need 0", out_valid); end
        if (epoch !== 1'b0) begin errors++; $display("FAIL arst_epoch got=%b need 0", epoch); end
        if (mispredict_cnt !== 4'd0) begin errors++; $display("FAIL arst_cnt got=%h need 0", mispredict_cnt); end
        if (out_pc !== 64'd0) begin errors++; $display("FAIL arst_pc got=%h need 0", out_pc); end
        if (redirect_pc !== 64'd0) begin errors++; $display("FAIL arst_redirect_pc got=%h need 0", redirect_pc); end
        m_epoch = 1'b0;
        m_cnt   = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks += 2;
            if (redirect_valid !== 1'b0) begin errors++; $display("FAIL arst_post_redirect k=%0d got=%b need 0", k, redirect_valid); end
            if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_post_valid k=%0d got=%b need 0", k, out_valid); end
        end
    endtask

    initial begin
        in_valid      = 1'b0;
        in_pc         = '0;
        in_sum        = '0;
        in_c_out      = 1'b0;
        in_v_flag     = 1'b0;
        in_n_flag     = 1'b0;
        in_z_flag     = 1'b0;
        in_is_branch  = 1'b0;
        in_is_jump    = 1'b0;
        in_funct3     = 3'b000;
        in_target     = '0;
        in_pred_taken = 1'b0;
        in_epoch      = 1'b0;
        out_ready     = 1'b1;
        test_reset();
        test_beq_mispredict();
        test_blt_bltu();
        test_squash();
        test_back_to_back_stall();
        test_random();
        test_wrap_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_stage.md
Name: branch_resolve_stage

Overview:
- EX-stage consumer of the 64-bit adder's flag outputs (c_out, v_flag, n_flag, z_flag) and its sum.
- For branches the adder computes rs1 + ~rs2 + 1. This block evaluates the RISC-V branch condition from those flags and compares the outcome against the front-end prediction.
- It registers the result into the EX/MEM boundary under a valid/ready handshake and issues a one-cycle redirect on mispredict.
- An epoch bit squashes wrong-path instructions still in flight after a redirect.

Parameters:
- XLEN, 64, datapath and PC width.
- CNT_W, 32, width of the saturating mispredict counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream holds a valid EX result
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction PC
- in_sum  in  XLEN  adder sum; ALU result for non-branches
- in_c_out  in  1  adder carry out
- in_v_flag  in  1  adder signed overflow
- in_n_flag  in  1  adder sum[XLEN-1]
- in_z_flag  in  1  adder sum == 0
- in_is_branch  in  1  conditional branch
- in_is_jump  in  1  JAL/JALR, unconditionally taken
- in_funct3  in  3  branch type
- in_target  in  XLEN  precomputed taken target
- in_pred_taken  in  1  front-end prediction
- in_epoch  in  1  epoch tag attached at fetch
- out_valid  out  1  registered result valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  registered PC
- out_result  out  XLEN  in_sum for ALU ops; pc+4 for jumps
- out_taken  out  1  resolved direction
- redirect_valid  out  1  one-cycle mispredict pulse
- redirect_pc  out  XLEN  correct next PC
- epoch  out  1  current epoch, fed back to fetch
- mispredict_cnt  out  CNT_W  saturating mispredict count

Behaviour:
- Reset (async, rst_n=0) values:
  - out_valid=0, redirect_valid=0, epoch=0, mispredict_cnt=0, out_taken=0.
  - out_pc, out_result and redirect_pc reset to 0.
- Ready rule: in_ready = !out_valid || out_ready. It is combinational and does not depend on in_valid.
- Accept occurs when in_valid && in_ready. Latency from accept to out_valid is 1 cycle.
- out_* holds stable while out_valid && !out_ready.
- Epoch check: when in_epoch != epoch, the transaction is accepted and dropped.
  - out_valid is 0 next cycle unless other data is loaded.
  - No redirect is issued and the counter does not change.
- Condition for in_funct3 (taken when):
  - 000 BEQ: z
  - 001 BNE: !z
  - 100 BLT: n^v
  - 101 BGE: !(n^v)
  - 110 BLTU: !c_out
  - 111 BGEU: c_out
  - 010 and 011 are illegal: treated as not-taken.
- Taken resolution:
  - in_is_jump forces taken=1 and takes priority over in_is_branch.
  - With neither set, taken=0 and no mispredict is possible.
- Mispredict occurs when (in_is_branch || in_is_jump) && taken != in_pred_taken, on a matching-epoch accept.
- On the next edge after a mispredict:
  - redirect_valid=1 for exactly one cycle.
  - redirect_pc = taken ? in_target : in_pc+4. The sum wraps modulo 2^XLEN.
  - epoch toggles.
  - mispredict_cnt increments, saturating at all-ones.
- redirect_valid is independent of out_ready. It pulses even if the output is later stalled, and it never re-pulses for the same instruction.
- State is epoch-based with two effective modes:
  - RUN: inputs match the epoch.
  - SQUASH: inputs mismatch after a toggle. The stage stays here until upstream supplies in_epoch == epoch; there is no timeout.
- Simultaneous events: a mispredict accept and a downstream pop in the same cycle is legal. Output reloads; back-to-back throughput is 1 per cycle.
- Reset mid-operation: all in-flight state is discarded immediately and no redirect is issued after release.

Decomposition:
- Shared package:
  - funct3 constants (BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU).
  - XLEN default.
  - The struct/bundle of adder flags {c_out, v, n, z}.
- Sub-module branch_cond_eval: combinational funct3 + flags -> taken. It is reused by any later compressed-branch path.

Test Plan:
- BEQ with rs1=rs2=5 (flags z=1, c=1), pred_taken=0, target=0x1000 -> out_taken=1 one cycle later; redirect_valid pulse with redirect_pc=0x1000; epoch 0->1; mispredict_cnt=1.
- BLT with rs1=-1, rs2=1 (n=1, v=0), pred_taken=1 -> taken=1, no redirect, epoch unchanged. Then BLTU with the same operands (c=1) -> taken=0 and mispredict; redirect_pc=pc+4.
- After a mispredict, feed 3 transactions with in_epoch=0 -> all accepted (in_ready=1), out_valid stays 0, no redirect. The next transaction with in_epoch=1 is output normally.
- out_ready=0 for 4 cycles with out_valid=1 -> in_ready=0, out_* bit-stable. Raising out_ready while in_valid=1 gives a pop+load in the same cycle with no bubble.
- pc=0xFFFF_FFFF_FFFF_FFFC, not-taken mispredict -> redirect_pc=0 (wrap). Preload mispredict_cnt to all-ones via repeated mispredicts (CNT_W=4 config) -> holds at 0xF.
- Assert rst_n=0 asynchronously mid-stall with out_valid=1 and epoch=1 -> outputs clear before the next clk edge; epoch=0, mispredict_cnt=0.
